axis_demux1_n: RTL and testbench

Parametrised AXI-Stream 1-to-N demultiplexer, successor to the two-way demux. It routes one input stream to one of `CH` output channels through a registered skid stage, so every handshake signal is registered and throughput is one beat per clock. An optional frame-lock mode latches the destination at the first beat of a frame and holds it until `tlast`, so a `sel` change can never split a frame. It sits between a framing source and per-channel consumers such as interleaver branches.

---
 rtl/axis_pkg.sv | 12 +
 rtl/axis_skid_reg.sv | 44 ++++
 rtl/axis_demux1_n.sv | 76 +++++++
 tb/tb_axis_demux1_n.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// axis_pkg: shared constants and helpers for the AXI-Stream demux family
package axis_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCKED = 1'b1;
  localparam int DROP_CNT_W = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/axis_skid_reg.sv
// axis_skid_reg: two-entry registered skid buffer with a flop-driven input ready
module axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] skid_data;
  logic         skid_valid;
  logic         push;
  logic         adv;
  assign push = in_valid && in_ready;
  assign adv  = !out_valid || out_ready;
  // main stage refills from the skid entry first, otherwise from the incoming beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= skid_valid || push;
      out_data  <= skid_valid ? skid_data : in_data;
    end
  // skid entry captures a beat that arrives while the main stage is stalled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (push && !adv) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end else if (adv) begin
      skid_valid <= 1'b0;
    end
  // ready tracks next-cycle skid emptiness so it leaves straight from a flop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) in_ready <= 1'b0;
    else        in_ready <= adv || !(skid_valid || push);
endmodule

// File: rtl/axis_demux1_n.sv
// axis_demux1_n: registered AXI-Stream 1-to-N demux with optional per-frame destination lock
module axis_demux1_n
  import axis_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CH         = 4,
  parameter int SEL_W      = clog2(CH),
  parameter int FRAME_LOCK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      sel,
  input  logic [WIDTH-1:0]      s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [CH*WIDTH-1:0]   m_axis_tdata,
  output logic [CH-1:0]         m_axis_tvalid,
  output logic [CH-1:0]         m_axis_tlast,
  input  logic [CH-1:0]         m_axis_tready,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam int DW = WIDTH + 1 + SEL_W;
  localparam logic [SEL_W:0] CH_L = (SEL_W + 1)'(CH);
  logic             state;
  logic             state_d;
  logic [SEL_W-1:0] dest_q;
  logic [SEL_W-1:0] dest;
  logic             accept;
  logic             in_range;
  logic [WIDTH-1:0] h_data;
  logic             h_last;
  logic [SEL_W-1:0] h_dest;
  logic             h_valid;
  logic             h_ready;
  assign dest     = (state == ST_LOCKED) ? dest_q : sel;
  assign in_range = {1'b0, dest} < CH_L;
  assign accept   = s_axis_tvalid && s_axis_tready;
  // frame-lock state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  // open a frame on a non-last beat, close it on any accepted last beat
  always_comb
    state_d = (FRAME_LOCK != 0 && accept) ? (s_axis_tlast ? ST_IDLE : ST_LOCKED) : state;
  // busy marks an open locked frame
  always_comb
    busy = (state == ST_LOCKED);
  // destination captured at the first beat of each frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                        dest_q <= '0;
    else if (accept && state == ST_IDLE) dest_q <= sel;
  // saturating count of beats swallowed for an out-of-range destination
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                      drop_cnt <= '0;
    else if (accept && !in_range && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
  axis_skid_reg #(.W(DW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({s_axis_tdata, s_axis_tlast, dest}),
    .in_valid  (s_axis_tvalid && in_range),
    .in_ready  (s_axis_tready),
    .out_data  ({h_data, h_last, h_dest}),
    .out_valid (h_valid),
    .out_ready (h_ready)
  );
  assign h_ready = |(m_axis_tvalid & m_axis_tready);
  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic hit;
    assign hit                          = h_valid && h_dest == SEL_W'(k);
    assign m_axis_tvalid[k]             = hit;
    assign m_axis_tlast[k]              = hit && h_last;
    assign m_axis_tdata[k*WIDTH+:WIDTH] = hit ? h_data : '0;
  end
endmodule

// File: tb/tb_axis_demux1_n.sv
// tb_axis_demux1_n: directed and randomised checks of the demux against a queue model
module tb_axis_demux1_n;
  logic clk, rst_n;
  logic [1:0]  a_sel;
  logic [7:0]  a_td;
  logic        a_tv, a_tl, a_tr;
  logic [31:0] a_md;
  logic [3:0]  a_mv, a_ml, a_mr;
  logic        a_busy;
  logic [15:0] a_drop;
  logic [1:0]  b_sel;
  logic [7:0]  b_td;
  logic        b_tv, b_tl, b_tr;
  logic [23:0] b_md;
  logic [2:0]  b_mv, b_ml, b_mr;
  logic        b_busy;
  logic [15:0] b_drop;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [1:0] ch;
    logic [7:0] d;
    logic       l;
  } beat_t;
  beat_t q[$];
  bit in_frame;
  logic [1:0] fdest;
  int acc_cnt = 0;
  bit mon_en;

  axis_demux1_n #(.WIDTH(8), .CH(4), .FRAME_LOCK(1)) u_a (
    .clk(clk), .rst_n(rst_n), .sel(a_sel),
    .s_axis_tdata(a_td), .s_axis_tvalid(a_tv), .s_axis_tlast(a_tl), .s_axis_tready(a_tr),
    .m_axis_tdata(a_md), .m_axis_tvalid(a_mv), .m_axis_tlast(a_ml), .m_axis_tready(a_mr),
    .busy(a_busy), .drop_cnt(a_drop)
  );
  axis_demux1_n #(.WIDTH(8), .CH(3), .FRAME_LOCK(0)) u_b (
    .clk(clk), .rst_n(rst_n), .sel(b_sel),
    .s_axis_tdata(b_td), .s_axis_tvalid(b_tv), .s_axis_tlast(b_tl), .s_axis_tready(b_tr),
    .m_axis_tdata(b_md), .m_axis_tvalid(b_mv), .m_axis_tlast(b_ml), .m_axis_tready(b_mr),
    .busy(b_busy), .drop_cnt(b_drop)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // reference: at most two beats in flight, delivered in order to their resolved channel
  always @(negedge clk) begin
    bit mr, h;
    logic [1:0] d;
    if (rst_n && mon_en) begin
      mr = q.size() < 2;
      chk("a_ready", a_tr, mr);
      chk("a_busy", a_busy, in_frame);
      for (int k = 0; k < 4; k++) begin
        h = q.size() != 0 && q[0].ch == k;
        chk("a_tvalid", a_mv[k], h);
        chk("a_tlast", a_ml[k], h && q[0].l);
        chk("a_tdata", a_md[k*8+:8], h ? q[0].d : 8'h00);
      end
      if (q.size() != 0 && a_mr[q[0].ch]) void'(q.pop_front());
      if (a_tv && mr) begin
        d = in_frame ? fdest : a_sel;
        if (!in_frame) fdest = a_sel;
        in_frame = !a_tl;
        q.push_back('{ch: d, d: a_td, l: a_tl});
        acc_cnt++;
      end
    end
  end

  initial begin
    int n;
    rst_n = 0; mon_en = 0; in_frame = 0; fdest = 0;
    a_sel = 0; a_td = 0; a_tv = 0; a_tl = 0; a_mr = 0;
    b_sel = 0; b_td = 0; b_tv = 0; b_tl = 0; b_mr = 0;
    #12;
    chk("rst_a_tready", a_tr, 0);
    chk("rst_a_tvalid", a_mv, 0);
    chk("rst_a_tlast", a_ml, 0);
    chk("rst_a_tdata", a_md, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_drop", a_drop, 0);
    chk("rst_b_tready", b_tr, 0);
    chk("rst_b_tvalid", b_mv, 0);
    @(negedge clk) rst_n = 1;
    step;
    chk("a_tready_rise", a_tr, 1);
    chk("b_tready_rise", b_tr, 1);
    mon_en = 1;

    b_mr = 3'b111; b_sel = 2; b_td = 8'h11; b_tv = 1;
    step;
    chk("b_beat11_valid", b_mv, 3'b100);
    chk("b_beat11_data", b_md, 24'h110000);
    b_td = 8'h22;
    step;
    chk("b_beat22_valid", b_mv, 3'b100);
    chk("b_beat22_data", b_md, 24'h220000);
    b_sel = 1; b_td = 8'h33;
    step;
    chk("b_nolock_valid", b_mv, 3'b010);
    chk("b_nolock_data", b_md, 24'h003300);
    chk("b_busy_zero", b_busy, 0);
    b_tv = 0;
    step;
    chk("b_idle_valid", b_mv, 0);
    chk("b_idle_data", b_md, 0);

    b_sel = 3; b_tv = 1;
    repeat (5) begin
      b_td = 8'($urandom);
      step;
      chk("b_drop_quiet", b_mv, 0);
      chk("b_drop_ready", b_tr, 1);
    end
    b_tv = 0;
    step;
    chk("b_drop5", b_drop, 5);

    a_mr = 4'hF; a_sel = 1; a_tv = 1;
    for (int i = 0; i < 4; i++) begin
      a_td = 8'(8'hA0 + i);
      a_tl = (i == 3);
      step;
      chk("a_lock_ch", a_mv, 4'b0010);
      chk("a_lock_data", a_md, {16'h0, a_td, 8'h0});
      chk("a_lock_busy", a_busy, i != 3);
      if (i == 1) a_sel = 3;
    end
    a_td = 8'hB0; a_tl = 1;
    step;
    chk("a_next_frame_ch", a_mv, 4'b1000);
    chk("a_next_frame_data", a_md, 32'hB0000000);
    chk("a_single_beat_busy", a_busy, 0);
    a_tv = 0;
    step;
    chk("a_idle_valid", a_mv, 0);

    a_sel = 0; a_tl = 0; a_tv = 1;
    repeat (3) begin a_td = 8'($urandom); step; end
    a_mr = 4'hE;
    n = 0;
    repeat (5) begin
      a_td = 8'($urandom);
      n += int'(a_tr);
      step;
    end
    chk("bp_one_extra", n, 1);
    chk("bp_ready_low", a_tr, 0);
    chk("bp_head_held", a_mv, 4'b0001);
    a_mr = 4'hF;
    repeat (6) begin a_td = 8'($urandom); step; end
    a_tv = 0;
    repeat (4) step;
    chk("bp_drained", a_mv, 0);
    chk("bp_ready_back", a_tr, 1);

    a_mr = 4'h0; a_tv = 1;
    repeat (2) begin a_td = 8'($urandom); step; end
    chk("rst_pre_busy", a_busy, 1);
    chk("rst_pre_valid", a_mv, 4'b0001);
    mon_en = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_tvalid", a_mv, 0);
    chk("arst_tlast", a_ml, 0);
    chk("arst_tdata", a_md, 0);
    chk("arst_busy", a_busy, 0);
    chk("arst_tready", a_tr, 0);
    q.delete(); in_frame = 0;
    a_tv = 0; a_mr = 4'hF; a_sel = 2;
    @(negedge clk) rst_n = 1;
    step;
    chk("rerst_ready", a_tr, 1);
    mon_en = 1;
    a_tv = 1; a_tl = 0; a_td = 8'h5A;
    step;
    chk("newframe_ch", a_mv, 4'b0100);
    chk("newframe_busy", a_busy, 1);
    a_tl = 1; a_sel = 1; a_td = 8'h5B;
    step;
    chk("newframe_locked_ch", a_mv, 4'b0100);
    chk("newframe_closed", a_busy, 0);
    a_tv = 0;
    step;

    fork
      begin
        int start, cyc, m;
        start = acc_cnt; cyc = 0;
        while (acc_cnt - start < 10000 && cyc < 40000) begin
          a_tv  = $urandom_range(0, 3) != 0;
          a_tl  = $urandom_range(0, 3) == 0;
          a_sel = 2'($urandom);
          a_td  = 8'($urandom);
          a_mr  = 4'($urandom) | 4'($urandom);
          step;
          cyc++;
        end
        chk("rand_budget", cyc < 40000, 1);
        a_tv = 0; a_mr = 4'hF;
        repeat (4) step;
        chk("rand_drained", a_mv, 0);
        a_tl = 0; a_tv = 1; m = 0;
        repeat (100) begin
          a_td = 8'($urandom);
          m += int'(a_tr);
          step;
        end
        chk("full_rate", m, 100);
        a_tv = 0;
        repeat (3) step;
      end
      begin
        bit seen;
        seen = 0; b_sel = 3; b_tv = 1;
        repeat (70000) begin
          step;
          seen |= |b_mv;
        end
        b_tv = 0;
        step;
        chk("b_saturate", b_drop, 16'hFFFF);
        chk("b_sat_quiet", seen, 0);
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
